output_buffer_ctrl: RTL and testbench
=====================================

OUTPUT_BUFFER_CTRL -- requirements
Module: output_buffer_ctrl

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset.
REQ-002 SHALL have these parameters (name, default, meaning):
- NUM_OPS_W, 8, width of the operation-count input and counter.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  single-cycle request to start a result sequence.
- abort_i  in  1  synchronous abort; sequence terminates.
- pim_mode_i  in  3  requested mode: 3'b101 parallel, 3'b110 rbr.
- num_ops_i  in  NUM_OPS_W  number of encoded results to produce.
- eflash_valid_i  in  1  eFlash 8-bit sense data valid this cycle.
- out_ready_i  in  1  consumer accepts the encoded result.
- pim_mode_o  out  3  latched mode; drives the encoder mode input.
- buf_write_en_1_o  out  1  write the eFlash sample into buffer slot 1.
- buf_write_en_2_o  out  1  write the eFlash sample into buffer slot 2.
- buf_read_en_o  out  1  buffer read enable; gates the encoder output.
- out_valid_o  out  1  encoded result valid.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse when the last result is accepted.
- err_o  out  1  one-cycle pulse when a start is rejected.

Function
REQ-004 SHALL implement the states IDLE, CAP1, CAP2 and READ.
REQ-005 In IDLE, start_i with pim_mode_i in {101,110} and num_ops_i!=0 SHALL:
- latch the mode into pim_mode_o;
- latch num_ops_i;
- clear the op counter;
- go to CAP1 on the next cycle.
REQ-006 In IDLE, start_i with any other mode or with num_ops_i==0 SHALL:
- pulse err_o on the next cycle;
- stay in IDLE;
- leave pim_mode_o unchanged.
REQ-007 start_i SHALL be ignored outside IDLE (no err_o, no state change).
REQ-008 buf_write_en_1_o SHALL be the combinational value (state==CAP1 && eflash_valid_i), so the buffer captures data in the same cycle it is valid.
REQ-009 buf_write_en_2_o SHALL be the combinational value (state==CAP2 && eflash_valid_i).
REQ-010 buf_write_en_1_o and buf_write_en_2_o SHALL never be high together.
REQ-011 CAP1 transitions on eflash_valid_i SHALL be:
- to CAP2 when the latched mode is parallel;
- to READ when the latched mode is rbr.
REQ-012 CAP2 SHALL go to READ on eflash_valid_i.
REQ-013 CAP1 and CAP2 SHALL wait indefinitely without eflash_valid_i.
REQ-014 In READ, buf_read_en_o and out_valid_o SHALL both be 1 and held until out_valid_o && out_ready_i.
REQ-015 First-result latency SHALL be:
- rbr: out_valid_o rises 1 cycle after the CAP1 capture edge;
- parallel: out_valid_o rises 1 cycle after the CAP2 capture edge.
REQ-016 On an accepted transfer with count < latched_num_ops-1, the controller SHALL increment the count and go to CAP1.
REQ-017 On an accepted transfer with count == latched_num_ops-1, the controller SHALL:
- pulse done_o for one cycle;
- go to IDLE.
REQ-018 The op counter SHALL be NUM_OPS_W wide and SHALL never wrap; num_ops_i = 2^NUM_OPS_W-1 produces exactly that many results.
REQ-019 busy_o SHALL be 1 in every state except IDLE.
REQ-020 abort_i SHALL have priority over all other inputs in any non-IDLE state:
- go to IDLE on the next edge;
- deassert all enables and out_valid_o from that edge;
- no done_o, no err_o.
REQ-021 When abort_i coincides with an accepted transfer, the transfer SHALL count as consumed and done_o SHALL be suppressed.
REQ-022 eflash_valid_i SHALL be ignored in IDLE and READ.
REQ-023 pim_mode_o SHALL remain stable for the whole sequence and SHALL hold its value after returning to IDLE.

Reset
REQ-024 rst_i high SHALL asynchronously force:
- state to IDLE;
- the counter and latched num_ops to 0;
- pim_mode_o to 3'b000;
- every 1-bit output to 0.
REQ-025 Reset asserted mid-sequence SHALL discard the sequence; after release the block SHALL require a new start_i.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- rbr, num_ops=1: start, eflash_valid at cycle 3 -> buf_write_en_1_o=1 at cycle 3; out_valid_o/buf_read_en_o=1 at cycle 4; with out_ready_i=1, done_o at cycle 5; buf_write_en_2_o never asserted.
- parallel, num_ops=2, out_ready tied 1 -> write sequence we1, we2, read, we1, we2, read; exactly 2 transfers; one done_o; pim_mode_o=101 throughout.
- Backpressure: READ with out_ready_i=0 for 5 cycles -> out_valid_o and buf_read_en_o held 5+ cycles; count unchanged; eflash_valid_i pulses produce no write enable.
- Bad start: pim_mode_i=3'b011 or num_ops_i=0 -> err_o single pulse; busy_o stays 0; pim_mode_o unchanged.
- abort_i in CAP2, parallel, num_ops=3 -> IDLE next cycle; no done_o; a subsequent valid start runs normally.
- rst_i pulsed in READ -> all outputs 0 immediately (asynchronously); IDLE after release; start_i during reset ignored.

Source files
------------

// File: rtl/output_buffer_ctrl.sv
// Output buffer sequencing controller: captures one (rbr) or two (parallel) eFlash samples,
// then presents one encoded result per operation until the requested count is consumed.
module output_buffer_ctrl #(
  parameter int unsigned NUM_OPS_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [2:0]           pim_mode_i,
  input  logic [NUM_OPS_W-1:0] num_ops_i,
  input  logic                 eflash_valid_i,
  input  logic                 out_ready_i,
  output logic [2:0]           pim_mode_o,
  output logic                 buf_write_en_1_o,
  output logic                 buf_write_en_2_o,
  output logic                 buf_read_en_o,
  output logic                 out_valid_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam logic [2:0] ModePar = 3'b101;
  localparam logic [2:0] ModeRbr = 3'b110;

  typedef enum logic [1:0] {StIdle, StCap1, StCap2, StRead} state_e;

  state_e               state_q, state_d;
  logic [2:0]           mode_q, mode_d;
  logic [NUM_OPS_W-1:0] nops_q, nops_d;
  logic [NUM_OPS_W-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 start_ok;
  logic                 accept;

  assign start_ok = ((pim_mode_i == ModePar) || (pim_mode_i == ModeRbr)) &&
                    (num_ops_i != '0);
  assign accept   = (state_q == StRead) && out_ready_i;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    nops_d  = nops_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (start_ok) begin
            mode_d  = pim_mode_i;
            nops_d  = num_ops_i;
            cnt_d   = '0;
            state_d = StCap1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StCap1: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (eflash_valid_i) begin
          state_d = (mode_q == ModePar) ? StCap2 : StRead;
        end
      end
      StCap2: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (eflash_valid_i) begin
          state_d = StRead;
        end
      end
      StRead: begin
        if (abort_i) begin
          // An accepted result still counts, but the sequence ends silently.
          if (accept) cnt_d = cnt_q + NUM_OPS_W'(1);
          state_d = StIdle;
        end else if (accept) begin
          if (cnt_q == nops_q - NUM_OPS_W'(1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q + NUM_OPS_W'(1);
            state_d = StCap1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      mode_q  <= 3'b000;
      nops_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      nops_q  <= nops_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign pim_mode_o       = mode_q;
  assign buf_write_en_1_o = (state_q == StCap1) && eflash_valid_i;
  assign buf_write_en_2_o = (state_q == StCap2) && eflash_valid_i;
  assign buf_read_en_o    = (state_q == StRead);
  assign out_valid_o      = (state_q == StRead);
  assign busy_o           = (state_q != StIdle);
  assign done_o           = done_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Bench for output_buffer_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the sequence.
module tb_output_buffer_ctrl;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic [2:0]   pim_mode_i = 3'b000;
  logic [W-1:0] num_ops_i = '0;
  logic         eflash_valid_i = 1'b0;
  logic         out_ready_i = 1'b0;
  logic [2:0]   pim_mode_o;
  logic         buf_write_en_1_o, buf_write_en_2_o, buf_read_en_o;
  logic         out_valid_o, busy_o, done_o, err_o;

  int checks = 0;
  int failures = 0;

  output_buffer_ctrl #(.NUM_OPS_W(W)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .pim_mode_i      (pim_mode_i),
    .num_ops_i       (num_ops_i),
    .eflash_valid_i  (eflash_valid_i),
    .out_ready_i     (out_ready_i),
    .pim_mode_o      (pim_mode_o),
    .buf_write_en_1_o(buf_write_en_1_o),
    .buf_write_en_2_o(buf_write_en_2_o),
    .buf_read_en_o   (buf_read_en_o),
    .out_valid_o     (out_valid_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a sequence is "active" with a number of samples still owed per op and a count of
  // results delivered so far; outputs follow from those quantities.
  bit       m_active = 0;
  int       m_need = 0;
  int       m_caps = 0;
  int       m_results = 0;
  int       m_total = 0;
  bit [2:0] m_mode = 3'b000;
  bit       m_err = 0;
  bit       m_done = 0;

  always @(posedge clk_i) begin
    bit n_err, n_done;
    n_err = 0;
    n_done = 0;
    if (rst_i) begin
      m_active = 0; m_mode = 3'b000; m_caps = 0; m_results = 0; m_total = 0;
    end else if (!m_active) begin
      if (start_i) begin
        if ((pim_mode_i == 3'b101 || pim_mode_i == 3'b110) && num_ops_i != 0) begin
          m_active = 1; m_mode = pim_mode_i; m_total = num_ops_i;
          m_need = (pim_mode_i == 3'b101) ? 2 : 1;
          m_caps = 0; m_results = 0;
        end else begin
          n_err = 1;
        end
      end
    end else if (abort_i) begin
      m_active = 0;
    end else if (m_caps < m_need) begin
      if (eflash_valid_i) m_caps++;
    end else if (out_ready_i) begin
      m_results++;
      if (m_results == m_total) begin
        m_active = 0;
        n_done = 1;
      end else begin
        m_caps = 0;
      end
    end
    m_err = n_err;
    m_done = n_done;
  end

  // Activity counters taken from the DUT, compared against literal totals by directed tests.
  int n_we1 = 0, n_we2 = 0, n_xfer = 0, n_done = 0, n_err = 0;

  always @(negedge clk_i) begin
    bit reading, e_we1, e_we2;
    reading = m_active && (m_caps == m_need);
    e_we1 = m_active && (m_caps == 0) && eflash_valid_i;
    e_we2 = m_active && (m_need == 2) && (m_caps == 1) && eflash_valid_i;
    if (rst_i) begin
      reading = 0; e_we1 = 0; e_we2 = 0;
    end
    chk("we1", buf_write_en_1_o, e_we1);
    chk("we2", buf_write_en_2_o, e_we2);
    chk("read_en", buf_read_en_o, reading);
    chk("out_valid", out_valid_o, reading);
    chk("busy", busy_o, rst_i ? 0 : m_active);
    chk("done", done_o, rst_i ? 0 : m_done);
    chk("err", err_o, rst_i ? 0 : m_err);
    chk("mode", pim_mode_o, rst_i ? 0 : m_mode);
    chk("we_exclusive", buf_write_en_1_o & buf_write_en_2_o, 0);
    n_we1 += buf_write_en_1_o;
    n_we2 += buf_write_en_2_o;
    n_xfer += (out_valid_o && out_ready_i);
    n_done += done_o;
    n_err += err_o;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_counts();
    n_we1 = 0; n_we2 = 0; n_xfer = 0; n_done = 0; n_err = 0;
  endtask

  task automatic kick(input logic [2:0] mode, input int nops);
    pim_mode_i = mode;
    num_ops_i = W'(nops);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    for (i = 0; i < budget && !done_o; i++) step();
    chk({name, "_done_seen"}, done_o, 1);
  endtask

  task automatic idle_inputs();
    start_i = 0; abort_i = 0; eflash_valid_i = 0; out_ready_i = 0;
  endtask

  initial begin
    rst_i = 1'b1;
    #12;
    chk("reset_busy", busy_o, 0);
    chk("reset_mode", pim_mode_o, 0);
    chk("reset_valid", out_valid_o, 0);
    rst_i = 1'b0;
    step();

    // rbr, one op
    clear_counts();
    kick(3'b110, 1);
    chk("rbr_busy", busy_o, 1);
    chk("rbr_mode", pim_mode_o, 6);
    eflash_valid_i = 1; #1;
    chk("rbr_we1", buf_write_en_1_o, 1);
    step();
    eflash_valid_i = 0;
    chk("rbr_valid", out_valid_o, 1);
    chk("rbr_read_en", buf_read_en_o, 1);
    out_ready_i = 1;
    step();
    out_ready_i = 0;
    chk("rbr_done", done_o, 1);
    chk("rbr_idle", busy_o, 0);
    step();
    chk("rbr_done_pulse", done_o, 0);
    chk("rbr_we2_count", n_we2, 0);

    // parallel, two ops, ready tied high
    clear_counts();
    eflash_valid_i = 1; out_ready_i = 1;
    kick(3'b101, 2);
    repeat (7) step();
    idle_inputs();
    step();
    chk("par_we1_count", n_we1, 2);
    chk("par_we2_count", n_we2, 2);
    chk("par_xfer_count", n_xfer, 2);
    chk("par_done_count", n_done, 1);
    chk("par_mode_hold", pim_mode_o, 5);

    // backpressure in READ, rbr two ops
    clear_counts();
    kick(3'b110, 2);
    eflash_valid_i = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      eflash_valid_i = i[0]; #1;
      chk("bp_valid_held", out_valid_o, 1);
      chk("bp_no_we", buf_write_en_1_o | buf_write_en_2_o, 0);
      step();
    end
    eflash_valid_i = 0;
    chk("bp_xfer_none", n_xfer, 0);
    out_ready_i = 1;
    step();
    chk("bp_back_to_cap", out_valid_o, 0);
    eflash_valid_i = 1;
    wait_done("bp", 10);
    idle_inputs();
    step();
    chk("bp_xfer_count", n_xfer, 2);

    // rejected starts leave mode and state alone
    clear_counts();
    kick(3'b011, 2);
    chk("bad_mode_err", err_o, 1);
    chk("bad_mode_busy", busy_o, 0);
    chk("bad_mode_keep", pim_mode_o, 6);
    step();
    chk("bad_mode_err_pulse", err_o, 0);
    kick(3'b101, 0);
    chk("bad_zero_err", err_o, 1);
    chk("bad_zero_keep", pim_mode_o, 6);
    step();
    chk("bad_err_count", n_err, 2);

    // abort in CAP2
    clear_counts();
    kick(3'b101, 3);
    eflash_valid_i = 1;
    step();
    eflash_valid_i = 0;
    abort_i = 1;
    step();
    abort_i = 0;
    chk("abort_idle", busy_o, 0);
    step();
    chk("abort_no_done", n_done, 0);
    eflash_valid_i = 1; out_ready_i = 1;
    kick(3'b110, 1);
    wait_done("after_abort", 10);
    idle_inputs();
    step();

    // asynchronous reset in READ, start held during reset
    kick(3'b110, 2);
    eflash_valid_i = 1;
    step();
    eflash_valid_i = 0;
    chk("pre_rst_valid", out_valid_o, 1);
    #2;
    rst_i = 1; start_i = 1; pim_mode_i = 3'b101; num_ops_i = 3;
    #1;
    chk("rst_async_valid", out_valid_o, 0);
    chk("rst_async_busy", busy_o, 0);
    chk("rst_async_mode", pim_mode_o, 0);
    step(); step();
    chk("rst_start_ignored", busy_o, 0);
    start_i = 0;
    rst_i = 0;
    step();
    chk("rst_idle_after", busy_o, 0);

    // largest op count: exactly 255 results
    clear_counts();
    eflash_valid_i = 1; out_ready_i = 1;
    kick(3'b101, 255);
    wait_done("max", 1000);
    idle_inputs();
    step();
    chk("max_xfer_count", n_xfer, 255);
    chk("max_done_count", n_done, 1);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      logic [2:0] modes [5];
      modes = '{3'b101, 3'b110, 3'b011, 3'b000, 3'b111};
      start_i = ($urandom % 6) == 0;
      pim_mode_i = modes[$urandom % 5];
      num_ops_i = W'($urandom % 5);
      eflash_valid_i = $urandom % 2;
      out_ready_i = ($urandom % 3) != 0;
      abort_i = ($urandom % 40) == 0;
      rst_i = ($urandom % 400) == 0;
      step();
    end
    rst_i = 0;
    idle_inputs();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
